bayer_pixel_packer: RTL and testbench
=====================================

// Module: bayer_pixel_packer
// PURPOSE
//  Upstream feeder for the brightness filter. Takes the camera's 8-bit sample stream
//  (R, G1, G2, B per pixel) and assembles 32-bit pixel words {R,G1,G2,B}.
//  Words are buffered in a small FIFO and presented on a valid/ready interface.
//  Tags the last pixel of each frame and flags frames that restart mid-pixel.
// PARAMETERS
//  PIXELS_PER_FRAME  307200  pixels per frame (640x480); pix_last counter modulus
//  FIFO_DEPTH        4       output word FIFO entries (power of 2, >=2)
// PORTS
//  clk          in   1   system clock, all logic rising-edge
//  rst          in   1   asynchronous reset, active-high
//  frame_start  in   1   1-cycle pulse: next accepted byte is R of pixel 0
//  byte_valid   in   1   byte_data valid this cycle
//  byte_data    in   8   camera sample
//  byte_ready   out  1   packer accepts byte this cycle (accept = valid & ready)
//  pix_valid    out  1   FIFO head word valid
//  pix_data     out  32  {R[31:24],G1[23:16],G2[15:8],B[7:0]} = brightness filter input
//  pix_last     out  1   head word is last pixel of frame
//  pix_ready    in   1   downstream consumes head (pop = pix_valid & pix_ready)
//  lane_err     out  1   1-cycle pulse: frame_start seen with partial pixel held
// BEHAVIOUR
//  Reset: lane=0, pixel count=0, FIFO empty; byte_ready=1, pix_valid=0,
//   pix_data=0, pix_last=0, lane_err=0.
//  Lane counter 0..3 steps on each accepted byte.
//   Lanes 0..2 store the byte in the R/G1/G2 holding registers.
//   Lane 3 pushes {R,G1,G2,byte} into the FIFO and wraps lane to 0.
//  byte_ready = !(lane==3 && FIFO full). Registered state only; no combinational
//   path from pix_ready.
//  Latency: 4th byte accepted in cycle N -> pix_valid=1 in cycle N+1 (FIFO was empty).
//  Push and pop in the same cycle: occupancy is unchanged, data order is preserved.
//  Pixel counter 0..PIXELS_PER_FRAME-1 increments on each push.
//   The word pushed at count PIXELS_PER_FRAME-1 carries last=1; counter then wraps to 0.
//   pix_last travels with its word through the FIFO.
//  frame_start:
//   - Clears lane and pixel counter.
//   - If lane!=0, pulses lane_err next cycle and discards the partial holding registers.
//   - Does NOT flush the FIFO; completed pixels still drain.
//  frame_start in the same cycle as an accepted byte: the byte is lane 0 (R) of
//   pixel 0 of the new frame.
//  pix_data/pix_last reflect the FIFO head only. When empty they hold their last
//   value (0 after reset).
//  pix_valid deasserts only after a pop empties the FIFO. Once asserted, the head
//   word is stable until popped.
//  Reset mid-operation: all state returns to reset values immediately;
//   in-flight words are lost.
// STRUCTURE
//  pixel_pkg:
//   - typedef pixel_t = packed struct {r,g1,g2,b} (8b each)
//   - lane constants LANE_R=0, LANE_G1=1, LANE_G2=2, LANE_B=3
//   - PIX_W=32
//  Sub-module pixel_fifo (#(WIDTH=33, DEPTH)):
//   - synchronous FIFO, rst async high
//   - push/pop/full/empty, head-registered output
//   - stores {last, pixel_t}
//  Top holds lane FSM, holding regs, pixel counter and lane_err logic.
// TESTING
//  1) Reset, frame_start, bytes 10,20,30,40 with pix_ready=1
//     -> one word 0x0A141E28 one cycle after byte 40; pix_last=0.
//  2) pix_ready=0, stream 5 pixels
//     -> 4 words buffered, byte_ready=0 at lane 3 of pixel 5;
//        pix_ready=1 drains words in order, then the 5th is accepted.
//  3) PIXELS_PER_FRAME=4, stream 8 pixels
//     -> pix_last=1 on words 4 and 8 only.
//  4) frame_start after 2 bytes (lane=2)
//     -> lane_err pulses once; next 4 bytes form pixel 0; no partial word emitted.
//  5) frame_start coincident with accepted byte 0xAA then 3 bytes
//     -> word 0xAA...... emitted as pixel 0.
//  6) Assert rst with 3 words in FIFO and lane=1
//     -> pix_valid=0, byte_ready=1 immediately; subsequent pixel packs from lane 0.

Source files
------------

// File: rtl/pixel_pkg.sv
// Shared types for the Bayer pixel packer: lane encoding, the packed pixel word
// and the FIFO entry that carries the end-of-frame tag alongside the pixel.
package pixel_pkg;

    localparam int PIX_W = 32;

    typedef enum logic [1:0] {
        LANE_R  = 2'd0,
        LANE_G1 = 2'd1,
        LANE_G2 = 2'd2,
        LANE_B  = 2'd3
    } lane_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g1;
        logic [7:0] g2;
        logic [7:0] b;
    } pixel_t;

    typedef struct packed {
        logic   last;
        pixel_t pix;
    } word_t;

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO with a registered head word; the head holds its last value
// while empty so downstream sees stable data.
module pixel_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d, remain;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             push_ok, pop_ok;

    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);
    assign dout  = dout_q;

    always_comb begin
        push_ok = push && !full;
        pop_ok  = pop && !empty;
        mem_d   = mem_q;
        if (push_ok) begin
            mem_d[wr_q] = din;
        end
        wr_d   = wr_q + AW'(push_ok);
        rd_d   = rd_q + AW'(pop_ok);
        cnt_d  = cnt_q + CW'(push_ok) - CW'(pop_ok);
        // Entries older than this cycle's push that survive the pop decide the next head.
        remain = cnt_q - CW'(pop_ok);
        dout_d = dout_q;
        if (remain != '0) begin
            dout_d = mem_q[rd_d];
        end else if (push_ok) begin
            dout_d = din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            dout_q <= '0;
        end else begin
            mem_q  <= mem_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
        end
    end

endmodule

// File: rtl/bayer_pixel_packer.sv
// Packs the camera byte stream (R,G1,G2,B) into 32-bit pixel words, tags the last
// pixel of each frame and flags frame restarts that cut a pixel short.
module bayer_pixel_packer #(
    parameter int PIXELS_PER_FRAME = 307200,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        pix_valid,
    output logic [31:0] pix_data,
    output logic        pix_last,
    input  logic        pix_ready,
    output logic        lane_err
);
    import pixel_pkg::*;

    localparam int CNT_W = (PIXELS_PER_FRAME > 1) ? $clog2(PIXELS_PER_FRAME) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PIXELS_PER_FRAME - 1);

    lane_e            lane_q, lane_d;
    logic [7:0]       r_q, r_d, g1_q, g1_d, g2_q, g2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lane_err_q, lane_err_d;
    logic             accept, push, fifo_full, fifo_empty;
    word_t            push_word, head_word;
    logic [PIX_W:0]   push_bits, head_bits;

    // Only the final byte needs FIFO space, so the stall depends on registered state only.
    assign byte_ready = !(lane_q == LANE_B && fifo_full);
    assign accept     = byte_valid && byte_ready;

    always_comb begin
        lane_d     = lane_q;
        r_d        = r_q;
        g1_d       = g1_q;
        g2_d       = g2_q;
        cnt_d      = cnt_q;
        lane_err_d = 1'b0;
        push       = 1'b0;
        push_word  = '{last: (cnt_q == CNT_MAX), pix: '{r: r_q, g1: g1_q, g2: g2_q, b: byte_data}};
        if (frame_start) begin
            lane_err_d = (lane_q != LANE_R);
            lane_d     = LANE_R;
            cnt_d      = '0;
            r_d        = '0;
            g1_d       = '0;
            g2_d       = '0;
            if (accept) begin
                r_d    = byte_data;
                lane_d = LANE_G1;
            end
        end else if (accept) begin
            case (lane_q)
                LANE_R:  begin r_d  = byte_data; lane_d = LANE_G1; end
                LANE_G1: begin g1_d = byte_data; lane_d = LANE_G2; end
                LANE_G2: begin g2_d = byte_data; lane_d = LANE_B;  end
                default: begin
                    push   = 1'b1;
                    lane_d = LANE_R;
                    cnt_d  = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_q     <= LANE_R;
            r_q        <= '0;
            g1_q       <= '0;
            g2_q       <= '0;
            cnt_q      <= '0;
            lane_err_q <= 1'b0;
        end else begin
            lane_q     <= lane_d;
            r_q        <= r_d;
            g1_q       <= g1_d;
            g2_q       <= g2_d;
            cnt_q      <= cnt_d;
            lane_err_q <= lane_err_d;
        end
    end

    assign push_bits = push_word;
    assign head_word = head_bits;

    pixel_fifo #(
        .WIDTH (PIX_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (push_bits),
        .pop   (pix_ready),
        .full  (fifo_full),
        .empty (fifo_empty),
        .dout  (head_bits)
    );

    assign pix_valid = !fifo_empty;
    assign pix_data  = head_word.pix;
    assign pix_last  = head_word.last;
    assign lane_err  = lane_err_q;

endmodule

// File: tb/tb_bayer_pixel_packer.sv
// Directed bench for bayer_pixel_packer with a short frame so end-of-frame tagging
// is reachable; popped words are compared against an expected queue.
module tb_bayer_pixel_packer;

    localparam int PPF = 4;

    logic        clk;
    logic        rst;
    logic        frame_start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        pix_valid;
    logic [31:0] pix_data;
    logic        pix_last;
    logic        pix_ready;
    logic        lane_err;

    int errors = 0;
    int checks = 0;
    int lasts_seen = 0;
    int l0;
    logic [32:0] exp_q[$];

    int         m_lane = 0;
    int         m_cnt  = 0;
    logic [7:0] m_r, m_g1, m_g2;

    bayer_pixel_packer #(
        .PIXELS_PER_FRAME (PPF),
        .FIFO_DEPTH       (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_ready  (byte_ready),
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .pix_last    (pix_last),
        .pix_ready   (pix_ready),
        .lane_err    (lane_err)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // reference model of the packer, fed with every accepted byte
    task automatic model_byte(input logic [7:0] b, input bit fs);
        if (fs) begin
            m_lane = 0;
            m_cnt  = 0;
        end
        case (m_lane)
            0: m_r  = b;
            1: m_g1 = b;
            2: m_g2 = b;
            default: begin
                exp_q.push_back({(m_cnt == PPF - 1), m_r, m_g1, m_g2, b});
                m_cnt = (m_cnt + 1) % PPF;
            end
        endcase
        m_lane = (m_lane + 1) % 4;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit fs);
        int n;
        n = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && n < 200) begin
            tick();
            n++;
        end
        chk("byte_accept_wait", 64'(n < 200), 64'd1);
        frame_start = fs;
        tick();
        model_byte(b, fs);
        byte_valid  = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        m_lane = 0;
        m_cnt  = 0;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        chk(tag, 64'(exp_q.size()), 64'd0);
        chk({tag, "_valid"}, 64'(pix_valid), 64'd0);
    endtask

    // scoreboard: the pop happens at the next rising edge, check the head now
    always @(negedge clk) begin
        if (!rst && pix_valid && pix_ready) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL pop_unexpected observed=%0h expected=none", {pix_last, pix_data});
            end
            if (exp_q.size() != 0) begin
                chk("pop_word", 64'({pix_last, pix_data}), 64'(exp_q.pop_front()));
                if (pix_last) lasts_seen++;
            end
        end
    end

    initial begin
        #50000;
        errors++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; frame_start = 1'b0; byte_valid = 1'b0; byte_data = '0; pix_ready = 1'b0;
        #1;
        tick();
        tick();
        chk("rst_byte_ready", 64'(byte_ready), 64'd1);
        chk("rst_pix_valid", 64'(pix_valid), 64'd0);
        chk("rst_pix_data", 64'(pix_data), 64'd0);
        chk("rst_pix_last", 64'(pix_last), 64'd0);
        chk("rst_lane_err", 64'(lane_err), 64'd0);
        rst = 1'b0;
        tick();

        // 1) single pixel, one-cycle latency, head holds when empty
        pix_ready = 1'b1;
        send_byte(8'h0A, 1'b1);
        send_byte(8'h14, 1'b0);
        send_byte(8'h1E, 1'b0);
        send_byte(8'h28, 1'b0);
        chk("t1_valid", 64'(pix_valid), 64'd1);
        chk("t1_data", 64'(pix_data), 64'h0A141E28);
        chk("t1_last", 64'(pix_last), 64'd0);
        tick();
        chk("t1_empty", 64'(pix_valid), 64'd0);
        chk("t1_hold", 64'(pix_data), 64'h0A141E28);

        // 2) backpressure: four words fill the FIFO, fifth pixel stalls at its last byte
        pix_ready = 1'b0;
        l0 = lasts_seen;
        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < 4; k++) begin
                send_byte(8'(16 * (p + 1) + k), (p == 0 && k == 0));
            end
        end
        send_byte(8'h50, 1'b0);
        send_byte(8'h51, 1'b0);
        send_byte(8'h52, 1'b0);
        chk("t2_full_ready", 64'(byte_ready), 64'd0);
        chk("t2_valid", 64'(pix_valid), 64'd1);
        chk("t2_head", 64'(pix_data), 64'h10111213);
        tick();
        tick();
        chk("t2_still_stalled", 64'(byte_ready), 64'd0);
        chk("t2_head_stable", 64'(pix_data), 64'h10111213);
        pix_ready = 1'b1;
        send_byte(8'h53, 1'b0);
        wait_drain("t2_drain");
        chk("t2_lasts", 64'(lasts_seen - l0), 64'd1);

        // 3) frame of 4 pixels, two frames back to back
        l0 = lasts_seen;
        for (int p = 0; p < 8; p++) begin
            for (int k = 0; k < 4; k++) begin
                send_byte(8'(8'h80 + 4 * p + k), (p == 0 && k == 0));
            end
        end
        wait_drain("t3_drain");
        chk("t3_lasts", 64'(lasts_seen - l0), 64'd2);

        // 4) frame restart with a partial pixel held
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b0);
        pulse_fs();
        chk("t4_lane_err", 64'(lane_err), 64'd1);
        chk("t4_no_partial", 64'(pix_valid), 64'd0);
        tick();
        chk("t4_err_once", 64'(lane_err), 64'd0);
        send_byte(8'h31, 1'b0);
        send_byte(8'h32, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h34, 1'b0);
        chk("t4_data", 64'(pix_data), 64'h31323334);
        chk("t4_last", 64'(pix_last), 64'd0);
        wait_drain("t4_drain");

        // 5a) frame_start with the R byte, clean lane
        send_byte(8'hAA, 1'b1);
        chk("t5a_no_err", 64'(lane_err), 64'd0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b0);
        send_byte(8'hDD, 1'b0);
        chk("t5a_data", 64'(pix_data), 64'hAABBCCDD);
        wait_drain("t5a_drain");

        // 5b) frame_start with the R byte while a partial pixel is held
        send_byte(8'h01, 1'b0);
        send_byte(8'hA5, 1'b1);
        chk("t5b_err", 64'(lane_err), 64'd1);
        send_byte(8'hB6, 1'b0);
        chk("t5b_err_clear", 64'(lane_err), 64'd0);
        send_byte(8'hC7, 1'b0);
        send_byte(8'hD8, 1'b0);
        chk("t5b_data", 64'(pix_data), 64'hA5B6C7D8);
        chk("t5b_last", 64'(pix_last), 64'd0);
        wait_drain("t5b_drain");

        // 6) asynchronous reset with words buffered and a partial pixel
        pix_ready = 1'b0;
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 4; k++) begin
                send_byte(8'(8'hC0 + 4 * p + k), (p == 0 && k == 0));
            end
        end
        send_byte(8'hE0, 1'b0);
        chk("t6_pre_valid", 64'(pix_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", 64'(pix_valid), 64'd0);
        chk("t6_rst_ready", 64'(byte_ready), 64'd1);
        chk("t6_rst_data", 64'(pix_data), 64'd0);
        exp_q.delete();
        m_lane = 0;
        m_cnt  = 0;
        tick();
        rst = 1'b0;
        tick();
        pix_ready = 1'b1;
        send_byte(8'hF1, 1'b0);
        send_byte(8'hF2, 1'b0);
        send_byte(8'hF3, 1'b0);
        send_byte(8'hF4, 1'b0);
        chk("t6_data", 64'(pix_data), 64'hF1F2F3F4);
        chk("t6_last", 64'(pix_last), 64'd0);
        wait_drain("t6_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
